compare_serial: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands.
- Processes DIGIT bits per clock, MSB digit first, and stops at the first unequal digit.
- Supports unsigned and two's-complement modes, with a start/busy/done handshake.
- Used in datapaths where a full-width combinational comparator is too deep; successor to the fixed 2-bit lt/eq/gt comparator.

---
 rtl/compare_pkg.sv | 17 +
 rtl/compare_digit.sv | 16 +
 rtl/compare_serial.sv | 118 +++++++++++
 tb/tb_compare_serial.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package compare_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int calc_nstep(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int calc_idx_w(input int nstep);
      return (nstep > 1) ? $clog2(nstep) : 1;
   endfunction

endpackage

// File: rtl/compare_digit.sv
// Unsigned lt/eq/gt of two DIGIT-bit values; purely combinational, no flow control.
module compare_digit #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   assign lt = (a <  b);
   assign eq = (a == b);
   assign gt = (a >  b);

endmodule

// File: rtl/compare_serial.sv
// Serial MSB-first magnitude compare, DIGIT bits/cycle; done 1..WIDTH/DIGIT cycles after start.
// No backpressure: start is taken only in IDLE (incl. the done cycle), ignored while busy.
module compare_serial
   import compare_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int NSTEP = calc_nstep(WIDTH, DIGIT);
   localparam int IW    = calc_idx_w(NSTEP);
   localparam logic [IW-1:0] IDX_LAST = IW'(NSTEP - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             done_q, done_d;
   logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
   logic [WIDTH-1:0] sign_flip;
   logic             dig_lt, dig_eq, dig_gt;

   // Inverting both MSBs maps two's complement onto offset binary.
   assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

   // Operands shift left each step, so the current digit always sits at the top.
   compare_digit #(.DIGIT(DIGIT)) u_digit (
      .a  (a_q[WIDTH-1 -: DIGIT]),
      .b  (b_q[WIDTH-1 -: DIGIT]),
      .lt (dig_lt),
      .eq (dig_eq),
      .gt (dig_gt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a ^ sign_flip;
               b_d     = b ^ sign_flip;
               idx_d   = IDX_LAST;
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!dig_eq) begin
               lt_d    = dig_lt;
               gt_d    = dig_gt;
               eq_d    = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (idx_q == '0) begin
               lt_d    = 1'b0;
               gt_d    = 1'b0;
               eq_d    = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IW'(1);
               a_d   = a_q << DIGIT;
               b_d   = b_q << DIGIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign lt   = lt_q;
   assign eq   = eq_q;
   assign gt   = gt_q;

endmodule

// File: tb/tb_compare_serial.sv
// Bench for compare_serial: directed vector table, hand-written corner sequences, random vs reference model.
module tb_compare_serial;

   localparam int WIDTH = 16;
   localparam int DIGIT = 2;
   localparam int NSTEP = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             signed_mode;
   logic             busy, done, lt, eq, gt;

   int cyc      = 0;
   int acc_cyc  = 0;
   int tests    = 0;
   int fails    = 0;
   int done_cnt = 0;
   int acc_cnt  = 0;

   compare_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .busy        (busy),
      .done        (done),
      .lt          (lt),
      .eq          (eq),
      .gt          (gt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   typedef struct {
      string       nm;
      logic [15:0] va;
      logic [15:0] vb;
      logic        sm;
      logic [2:0]  res;   // {lt,eq,gt}
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: plain integer comparison; latency from the highest differing bit position.
   function automatic void model(input logic [15:0] ta, input logic [15:0] tb_v, input logic sm,
                                 output logic [2:0] res, output int lat);
      int va, vb;
      logic [15:0] x;
      va = sm ? int'($signed(ta)) : int'(ta);
      vb = sm ? int'($signed(tb_v)) : int'(tb_v);
      res = (va < vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
      x = ta ^ tb_v;
      lat = NSTEP;
      for (int h = WIDTH - 1; h >= 0; h--) begin
         if (x[h]) begin
            lat = NSTEP - h / DIGIT;
            break;
         end
      end
   endfunction

   // Called at a negedge while the DUT is idle; returns at the negedge after the accept edge.
   task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v, input logic sm);
      start       = 1'b1;
      a           = ta;
      b           = tb_v;
      signed_mode = sm;
      acc_cyc     = cyc + 1;
      acc_cnt++;
      @(negedge clk);
      start       = 1'b0;
      a           = 16'($urandom);
      b           = 16'($urandom);
      signed_mode = 1'($urandom);
   endtask

   task automatic finish_cmp(input string nm, input logic [2:0] er, input int el);
      bit ok;
      int lat;
      ok = 1'b0;
      for (int i = 0; i < 4 * NSTEP + 4; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      lat = cyc - acc_cyc;
      check({nm, "_done_seen"}, int'(ok), 1);
      check({nm, "_result"}, int'({lt, eq, gt}), int'(er));
      check({nm, "_latency"}, lat, el);
      check({nm, "_busy_in_done"}, int'(busy), 0);
   endtask

   initial begin
      logic [2:0]  er;
      int          el;
      logic [15:0] ta, tb_v, m;
      logic        sm;
      int          dc;

      vecs.push_back('{"u8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b001, 1});
      vecs.push_back('{"s8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b100, 1});
      vecs.push_back('{"u1234_eq",   16'h1234, 16'h1234, 1'b0, 3'b010, 8});
      vecs.push_back('{"u0001_0002", 16'h0001, 16'h0002, 1'b0, 3'b100, 8});
      vecs.push_back('{"s_m1_m2",    16'hFFFF, 16'hFFFE, 1'b1, 3'b001, 8});
      vecs.push_back('{"u0004_0008", 16'h0004, 16'h0008, 1'b0, 3'b100, 7});
      vecs.push_back('{"s_min_0",    16'h8000, 16'h0000, 1'b1, 3'b100, 1});
      vecs.push_back('{"u_ffff_0",   16'hFFFF, 16'h0000, 1'b0, 3'b001, 1});
      vecs.push_back('{"u0100_0",    16'h0100, 16'h0000, 1'b0, 3'b001, 4});
      vecs.push_back('{"s_eq_neg",   16'h9C40, 16'h9C40, 1'b1, 3'b010, 8});

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
      #12;
      check("reset_outputs", int'({busy, done, lt, eq, gt}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table, issued back to back
      foreach (vecs[i]) begin
         launch(vecs[i].va, vecs[i].vb, vecs[i].sm);
         check({vecs[i].nm, "_busy_run"}, int'(busy), 1);
         finish_cmp(vecs[i].nm, vecs[i].res, vecs[i].lat);
      end

      // Result hold with start low
      launch(16'h1234, 16'h1234, 1'b0);
      finish_cmp("hold_eq", 3'b010, 8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_outputs", int'({busy, done, lt, eq, gt}), int'(5'b00010));
      end

      // Start during busy ignored; start in done cycle accepted
      launch(16'h0004, 16'h0008, 1'b0);
      repeat (2) @(negedge clk);
      start = 1'b1; a = 16'hFFFF; b = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      finish_cmp("ignore_busy_start", 3'b100, 7);
      launch(16'h0000, 16'h0000, 1'b0);
      finish_cmp("b2b_in_done", 3'b010, 8);

      // Asynchronous reset mid-run
      @(negedge clk);
      launch(16'hAAAA, 16'hAAAA, 1'b0);
      repeat (3) @(negedge clk);
      dc = done_cnt;
      #2 rst_n = 1'b0;
      #1 check("abort_outputs", int'({busy, done, lt, eq, gt}), 0);
      repeat (2) @(negedge clk);
      check("abort_no_done", done_cnt, dc);
      acc_cnt--;
      rst_n = 1'b1;
      @(negedge clk);
      launch(16'h0000, 16'h4000, 1'b0);
      finish_cmp("after_reset", 3'b100, 1);
      #2 rst_n = 1'b0;
      #1 check("reset_clears_lt", int'({busy, done, lt, eq, gt}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomised against the reference model
      for (int n = 0; n < 10000; n++) begin
         ta = 16'($urandom);
         case ($urandom_range(0, 2))
            0: tb_v = 16'($urandom);
            1: begin
               m    = 16'((32'd1 << $urandom_range(0, 15)) - 1);
               tb_v = ta ^ (16'($urandom) & m);
            end
            default: tb_v = ta;
         endcase
         sm = 1'($urandom);
         model(ta, tb_v, sm, er, el);
         launch(ta, tb_v, sm);
         finish_cmp("random", er, el);
      end

      @(negedge clk);
      check("done_count", done_cnt, acc_cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
